// File: rtl/adder_rr_arbiter_if.sv
// Request/response bundle between N_REQ clients and the shared-adder arbiter.
// The arbiter takes the slave view; client logic (or a testbench) takes the master view.
interface adder_rr_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_c;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH:0]         rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter feeding one shared carry-select adder through an operand
// stage and a response stage; results come back tagged with the requester index.

module carry_select_adder #(
  parameter int WIDTH = 64,
  parameter int BLK   = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;
  localparam int PW   = NBLK * BLK;

  logic [PW-1:0] a_p, b_p, s_p;
  logic [NBLK:0] carry;
  logic [PW:0]   full;

  assign a_p      = PW'(a);
  assign b_p      = PW'(b);
  assign carry[0] = c_in;

  // Each block precomputes both carry-in cases; the incoming carry only selects.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0, s1;
    assign s0 = {1'b0, a_p[g*BLK +: BLK]} + {1'b0, b_p[g*BLK +: BLK]};
    assign s1 = {1'b0, a_p[g*BLK +: BLK]} + {1'b0, b_p[g*BLK +: BLK]} + (BLK+1)'(1);
    assign s_p[g*BLK +: BLK] = carry[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[g+1]        = carry[g] ? s1[BLK]     : s0[BLK];
  end

  assign full  = {carry[NBLK], s_p};
  assign sum   = full[WIDTH-1:0];
  assign c_out = full[WIDTH];
endmodule

module adder_rr_arbiter #(
  parameter int WIDTH = 64,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  adder_rr_arbiter_if.slave bus
);
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_c_q, op_c_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH:0]   rsp_result_q, rsp_result_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             rsp_adv, op_adv, xfer;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  int               idx;

  // Grant sees only req_valid and the pointer, never rsp_ready, so no loop exists.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  assign rsp_adv = !rsp_valid_q || bus.rsp_ready;
  assign op_adv  = !op_valid_q || rsp_adv;
  assign xfer    = grant_any && op_adv && !reset;

  assign bus.req_ready = reset ? '0 : (grant & {N_REQ{op_adv}});

  always_comb begin
    ptr_d        = ptr_q;
    op_valid_d   = op_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;

    if (op_adv) begin
      op_valid_d = xfer;
      if (xfer) begin
        op_a_d  = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
        op_b_d  = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
        op_c_d  = bus.req_c[grant_id];
        op_id_d = grant_id;
        ptr_d   = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
    end

    if (rsp_adv) begin
      rsp_valid_d  = op_valid_q;
      rsp_id_d     = op_id_q;
      rsp_result_d = {c_out, sum};
    end
  end

  carry_select_adder #(.WIDTH(WIDTH)) u_adder (
    .a     (op_a_q),
    .b     (op_b_q),
    .c_in  (op_c_q),
    .sum   (sum),
    .c_out (c_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
    if (reset) begin
      ptr_q        <= '0;
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= 1'b0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: directed scenarios plus a random regression, all
// checked every cycle against a queue-based transaction model of the arbiter.
module tb_adder_rr_arbiter;
  localparam int W    = 64;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic reset;

  adder_rr_arbiter_if #(.WIDTH(W), .N_REQ(N), .ID_W(ID_W)) bus ();

  adder_rr_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [W:0]  res;
    bit          shown;
  } txn_t;

  txn_t        sb[$];
  int          ptr_m;
  int          n_vec, n_err;
  int          n_xfer_dut, n_rsp_dut;
  logic [N-1:0] last_ready;
  bit          last_xfer;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the negedge, then advance the model at the posedge.
  task automatic cycle();
    int           exp_id;
    int           i;
    bit           full, exp_rv;
    logic [N-1:0] exp_ready;
    logic [W:0]   pend_res;
    txn_t         t;
    @(negedge clk);
    exp_id = -1;
    for (int k = 0; k < N; k++) begin
      i = (ptr_m + k) % N;
      if (exp_id < 0 && bus.req_valid[i]) exp_id = i;
    end
    full      = (sb.size() == 2) && !bus.rsp_ready;
    exp_ready = '0;
    pend_res  = '0;
    if (!reset && !full && exp_id >= 0) exp_ready[exp_id] = 1'b1;
    if (exp_id >= 0)
      pend_res = {1'b0, bus.req_a[exp_id*W +: W]} + {1'b0, bus.req_b[exp_id*W +: W]}
               + (W+1)'(bus.req_c[exp_id]);
    check("req_ready", 128'(bus.req_ready), 128'(exp_ready));
    exp_rv = (sb.size() > 0) && sb[0].shown;
    check("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 128'(bus.rsp_id), 128'(sb[0].id));
      check("rsp_result", 128'(bus.rsp_result), 128'(sb[0].res));
    end
    last_ready = bus.req_ready;
    last_xfer  = |(bus.req_valid & bus.req_ready);
    if (last_xfer) n_xfer_dut++;
    if (bus.rsp_valid && bus.rsp_ready) n_rsp_dut++;

    @(posedge clk);
    if (reset) begin
      sb.delete();
      ptr_m = 0;
    end else begin
      exp_rv = (sb.size() > 0) && sb[0].shown;
      if (exp_rv && bus.rsp_ready) void'(sb.pop_front());
      if (!exp_rv || bus.rsp_ready)
        for (int j = 0; j < sb.size(); j++) sb[j].shown = 1'b1;
      if (exp_ready != '0) begin
        t.id = exp_id; t.res = pend_res; t.shown = 1'b0;
        sb.push_back(t);
        ptr_m = (exp_id + 1) % N;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.req_valid[i]     = 1'b1;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
    bus.req_c[i]         = c;
  endtask

  task automatic drain();
    set_idle();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) cycle();
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  logic [W-1:0] ra, rb;
  int           n_rand, cyc, rsp_before;

  initial begin
    n_vec = 0; n_err = 0; n_xfer_dut = 0; n_rsp_dut = 0;
    ptr_m = 0;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    set_idle();
    do_reset();

    // Single request from requester 2: 5 + 3 + 1.
    cycle();
    set_req(2, 64'h5, 64'h3, 1'b1);
    cycle();
    check("t1_grant", 128'(last_ready), 128'(4'b0100));
    set_idle();
    check("t1_not_yet", 128'(bus.rsp_valid), 128'(0));
    cycle();
    check("t1_valid", 128'(bus.rsp_valid), 128'(1));
    check("t1_id", 128'(bus.rsp_id), 128'(2));
    check("t1_result", 128'(bus.rsp_result), 128'h9);
    drain();

    // All four requesters continuously valid: strict 0,1,2,3 rotation.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, W'(i * 100), W'(i + 7), i[0]);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t2_grant", 128'(last_ready), 128'(4'b0001 << (k % 4)));
      if (k >= 1) begin
        check("t2_rsp_valid", 128'(bus.rsp_valid), 128'(1));
        check("t2_rsp_id", 128'(bus.rsp_id), 128'((k - 1) % 4));
      end
    end
    drain();

    // Overflow into bit WIDTH.
    set_req(1, {W{1'b1}}, {W{1'b1}}, 1'b1);
    cycle();
    set_idle();
    cycle();
    check("t3_overflow", 128'(bus.rsp_result), 128'({1'b1, {W{1'b1}}}));
    drain();

    // Backpressure: five stalled cycles admit exactly two transfers.
    rsp_before = n_rsp_dut;
    n_xfer_dut = 0;
    bus.rsp_ready = 1'b0;
    set_req(0, 64'h1111, 64'h2222, 1'b0);
    set_req(1, 64'hdead_beef, 64'h1, 1'b1);
    for (int k = 0; k < 5; k++) cycle();
    check("t4_xfers", 128'(n_xfer_dut), 128'(2));
    check("t4_ready_low", 128'(bus.req_ready), 128'(0));
    drain();
    check("t4_delivered", 128'(n_rsp_dut - rsp_before), 128'(2));

    // Reset one cycle after a transfer drops it and restarts the pointer.
    set_req(2, 64'h77, 64'h88, 1'b0);
    cycle();
    set_idle();
    bus.req_valid = 4'b1010;
    reset = 1'b1;
    cycle();
    check("t5_ready_in_reset", 128'(last_ready), 128'(0));
    check("t5_dropped", 128'(bus.rsp_valid), 128'(0));
    reset = 1'b0;
    cycle();
    check("t5_regrant", 128'(last_ready), 128'(4'b0010));
    check("t5_still_empty", 128'(bus.rsp_valid), 128'(0));
    drain();

    // Random regression: 100 transfers with random valid, operands and rsp_ready.
    n_rand = 0;
    cyc = 0;
    while (n_rand < 100 && cyc < 3000) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) ra = {W{1'b1}};
        if ($urandom_range(0, 7) == 0) rb = {W{1'b1}};
        bus.req_valid[i]    = 1'($urandom_range(0, 1));
        bus.req_a[i*W +: W] = ra;
        bus.req_b[i*W +: W] = rb;
        bus.req_c[i]        = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_xfer) n_rand++;
      cyc++;
    end
    check("rand_count", 128'(n_rand), 128'(100));
    drain();
    check("rand_no_loss", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
